// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter/sequencer for the 64 B data memory.
// Port 0 = core load/store path, port 1 = debug/DMA path. One access in flight,
// IDLE -> ACCESS -> RESP, one-cycle registered response pulse to the owner.
// Optional feature: define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned halfword/word
// accesses and unlisted access codes with resp_err instead of touching memory.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [3:0]        p0_req_rw,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_resp_rdata,
  output logic              p0_resp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [3:0]        p1_req_rw,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_resp_rdata,
  output logic              p1_resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic [3:0]        lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_bad;
  logic [DATA_W-1:0] rdata_q;
  logic              v0_q;
  logic              v1_q;
  logic              err_q;

  logic              grant;
  logic              in_idle;
  logic              in_access;
  logic              p0_ready_c;
  logic              p1_ready_c;
  logic              hs;
  logic              acc_bad;
  logic [3:0]        sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  function automatic logic is_store(input logic [3:0] rw);
    return (rw == 4'b1011) || (rw == 4'b1110) || (rw == 4'b1111);
  endfunction

  function automatic logic is_load(input logic [3:0] rw);
    return rw[3] && !is_store(rw);
  endfunction

  // Tie-break: fixed priority to port 0, or the port that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (p0_req_valid && p1_req_valid)
      grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else if (p1_req_valid)
      grant = 1'b1;
  end

  assign in_idle      = rst && (state == S_IDLE);
  assign in_access    = rst && (state == S_ACCESS);
  assign p0_ready_c   = in_idle && p0_req_valid && !grant;
  assign p1_ready_c   = in_idle && p1_req_valid && grant;
  assign hs           = p0_ready_c || p1_ready_c;
  assign p0_req_ready = p0_ready_c;
  assign p1_req_ready = p1_ready_c;

  assign sel_rw    = grant ? p1_req_rw    : p0_req_rw;
  assign sel_addr  = grant ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = grant ? p1_req_wdata : p0_req_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  // Classify the request being accepted: unlisted code or misaligned half/word.
  always_comb begin
    acc_bad = 1'b0;
    if (!sel_rw[3]) begin
      acc_bad = 1'b1;
    end else begin
      case (sel_rw)
        4'b1001, 4'b1101, 4'b1110: acc_bad = sel_addr[0];
        4'b1010, 4'b1111:          acc_bad = |sel_addr[1:0];
        default:                   acc_bad = 1'b0;
      endcase
    end
  end
`else
  assign acc_bad = 1'b0;
`endif

  // Strobes are gated by rst so a reset landing mid-ACCESS never writes memory.
  assign mem_read  = in_access && !lat_bad && is_load(lat_rw);
  assign mem_write = in_access && !lat_bad && is_store(lat_rw);
  assign mem_addr  = in_access ? lat_addr  : '0;
  assign mem_wdata = in_access ? lat_wdata : '0;
  assign mem_rw    = in_access ? lat_rw    : '0;

  assign p0_resp_valid = rst && v0_q;
  assign p1_resp_valid = rst && v1_q;
  assign p0_resp_err   = rst && v0_q && err_q;
  assign p1_resp_err   = rst && v1_q && err_q;
  assign p0_resp_rdata = rst ? rdata_q : '0;
  assign p1_resp_rdata = rst ? rdata_q : '0;

  // Sequencer FSM: latch on handshake, access memory, pulse response, back to idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lat_rw     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_bad    <= 1'b0;
      rdata_q    <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          v0_q  <= 1'b0;
          v1_q  <= 1'b0;
          err_q <= 1'b0;
          if (hs) begin
            owner      <= grant;
            last_grant <= grant;
            lat_rw     <= sel_rw;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_bad    <= acc_bad;
            state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rdata_q <= (is_load(lat_rw) && !lat_bad) ? mem_rdata : '0;
          v0_q    <= !owner;
          v1_q    <= owner;
          err_q   <= lat_bad;
          state   <= S_RESP;
        end
        S_RESP: begin
          v0_q  <= 1'b0;
          v1_q  <= 1'b0;
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven requests with a response scoreboard, plus
// hand-written sequences for reset mid-access, round-robin and fixed priority.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          p0_req_valid, p0_req_ready, p0_resp_valid, p0_resp_err;
  logic [3:0]    p0_req_rw;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata, p0_resp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_resp_valid, p1_resp_err;
  logic [3:0]    p1_req_rw;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata, p1_resp_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_rw;

  logic          fp_p0_valid, fp_p1_valid, fp_p0_ready, fp_p1_ready;
  logic          fp_p0_rv, fp_p1_rv, fp_p0_err, fp_p1_err;
  logic [DW-1:0] fp_p0_rdata, fp_p1_rdata, fp_mem_wdata;
  logic          fp_mem_read, fp_mem_write;
  logic [AW-1:0] fp_mem_addr;
  logic [3:0]    fp_mem_rw;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_rw(p0_req_rw),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid),
    .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_rw(p1_req_rw),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid),
    .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .p0_req_valid(fp_p0_valid), .p0_req_ready(fp_p0_ready), .p0_req_rw(4'b1010),
    .p0_req_addr(6'd0), .p0_req_wdata(32'd0), .p0_resp_valid(fp_p0_rv),
    .p0_resp_rdata(fp_p0_rdata), .p0_resp_err(fp_p0_err),
    .p1_req_valid(fp_p1_valid), .p1_req_ready(fp_p1_ready), .p1_req_rw(4'b1010),
    .p1_req_addr(6'd4), .p1_req_wdata(32'd0), .p1_resp_valid(fp_p1_rv),
    .p1_resp_rdata(fp_p1_rdata), .p1_resp_err(fp_p1_err),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_rw(fp_mem_rw), .mem_rdata(32'd0)
  );

  // Byte-addressed 64 B little-endian memory with combinational read.
  logic [7:0] mem [64];
  logic       mem_load;
  logic [5:0] a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;
  always_comb begin
    a1 = mem_addr + 6'd1;
    a2 = mem_addr + 6'd2;
    a3 = mem_addr + 6'd3;
    b0 = mem[mem_addr];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    case (mem_rw)
      4'b1000: mem_rdata = {{24{b0[7]}}, b0};
      4'b1001: mem_rdata = {{16{b1[7]}}, b1, b0};
      4'b1010: mem_rdata = {b3, b2, b1, b0};
      4'b1100: mem_rdata = {24'd0, b0};
      4'b1101: mem_rdata = {16'd0, b1, b0};
      default: mem_rdata = 32'd0;
    endcase
  end
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= i[7:0];
      mem[5] <= 8'h80;
    end else if (mem_write) begin
      case (mem_rw)
        4'b1011: mem[mem_addr] <= mem_wdata[7:0];
        4'b1110: begin mem[mem_addr] <= mem_wdata[7:0]; mem[a1] <= mem_wdata[15:8]; end
        4'b1111: begin
          mem[mem_addr] <= mem_wdata[7:0];  mem[a1] <= mem_wdata[15:8];
          mem[a2] <= mem_wdata[23:16];      mem[a3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (p0_resp_valid || p1_resp_valid) begin
      chk("resp_one_port", {31'd0, p0_resp_valid & p1_resp_valid}, 32'd0);
      if (sbq.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_port", p1_resp_valid ? 32'd1 : 32'd0, mon_e.port);
        chk("resp_latency", cyc, mon_e.cyc + 2);
        chk("resp_rdata", p1_resp_valid ? p1_resp_rdata : p0_resp_rdata, mon_e.rdata);
        chk("resp_err", p1_resp_valid ? p1_resp_err : p0_resp_err, mon_e.err);
      end
    end
  end

  task automatic set_req(input int port, input logic v, input logic [3:0] rw,
                         input logic [5:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      p0_req_valid = v; p0_req_rw = rw; p0_req_addr = addr; p0_req_wdata = wd;
    end else begin
      p1_req_valid = v; p1_req_rw = rw; p1_req_addr = addr; p1_req_wdata = wd;
    end
  endtask

  task automatic do_req(input int port, input logic [3:0] rw, input logic [5:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input logic exp_r, input logic exp_w);
    int   waited;
    logic got;
    waited = 0;
    got    = 1'b0;
    @(negedge clk);
    set_req(port, 1'b1, rw, addr, wd);
    while (!got && waited < 10) begin
      #1;
      if ((port == 0) ? p0_req_ready : p1_req_ready) got = 1'b1;
      else begin @(negedge clk); waited++; end
    end
    if (!got) begin
      chk("ready_timeout", 32'd0, 32'd1);
      set_req(port, 1'b0, rw, addr, wd);
    end else begin
      chk("idle_mem_quiet", {30'd0, mem_read, mem_write}, 32'd0);
      sbq.push_back('{port, exp_rd, exp_err, cyc});
      @(negedge clk);
      set_req(port, 1'b0, rw, addr, wd);
      #1;
      chk("access_read", mem_read, exp_r);
      chk("access_write", mem_write, exp_w);
      if (exp_r || exp_w) chk("access_addr", mem_addr, addr);
      if (exp_w) chk("access_wdata", mem_wdata, wd);
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          port;
    logic [3:0]  rw;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        err;
    logic        rd;
    logic        wr;
  } vec_t;
  vec_t vt[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ng, last_hs, fp_cnt, w;
    logic exp_g, r0, r1, got;

    vt[0]  = '{0, 4'b1111, 6'd8,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b1};
    vt[1]  = '{0, 4'b1010, 6'd8,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1, 4'b1000, 6'd5,  32'h0,        32'hFFFFFF80, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1, 4'b1100, 6'd5,  32'h0,        32'h00000080, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1, 4'b1001, 6'd4,  32'h0,        32'hFFFF8004, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{0, 4'b1101, 6'd4,  32'h0,        32'h00008004, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1, 4'b1011, 6'd12, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b1};
    vt[7]  = '{0, 4'b1100, 6'd12, 32'h0,        32'h00000078, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1, 4'b1110, 6'd14, 32'h0000ABCD, 32'h0,        1'b0, 1'b0, 1'b1};
    vt[9]  = '{0, 4'b1001, 6'd14, 32'h0,        32'hFFFFABCD, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1, 4'b1010, 6'd16, 32'h0,        32'h13121110, 1'b0, 1'b1, 1'b0};
    vt[11] = '{0, 4'b1111, 6'd60, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1'b1};
    vt[12] = '{1, 4'b1010, 6'd60, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1, 1'b0};
    vt[13] = '{0, 4'b1100, 6'd63, 32'h0,        32'h000000CA, 1'b0, 1'b1, 1'b0};
    vt[14] = '{0, 4'b1010, 6'd2,  32'h0,        ALIGN ? 32'h0 : 32'h80040302, ALIGN, !ALIGN, 1'b0};
    vt[15] = '{1, 4'b0100, 6'd3,  32'h0,        32'h0,        ALIGN, 1'b0, 1'b0};

    rst = 1'b0;
    mem_load = 1'b1;
    fp_p0_valid = 1'b0;
    fp_p1_valid = 1'b0;
    set_req(0, 1'b0, 4'b0, 6'd0, 32'd0);
    set_req(1, 1'b0, 4'b0, 6'd0, 32'd0);
    @(negedge clk);
    mem_load = 1'b0;
    p0_req_valid = 1'b1;
    p0_req_rw = 4'b1010;
    #1;
    chk("rst_ready_held", p0_req_ready, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_resp_valid", {30'd0, p0_resp_valid, p1_resp_valid}, 32'd0);
    @(negedge clk);
    p0_req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("post_rst_rdata", p0_resp_rdata, 32'd0);
    chk("post_rst_err", {30'd0, p0_resp_err, p1_resp_err}, 32'd0);

    for (int i = 0; i < 16; i++)
      do_req(vt[i].port, vt[i].rw, vt[i].addr, vt[i].wd, vt[i].exp, vt[i].err, vt[i].rd, vt[i].wr);

    // Reset during ACCESS of sw addr 0: no write, no response.
    @(negedge clk);
    set_req(0, 1'b1, 4'b1111, 6'd0, 32'h00000055);
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin
      #1;
      if (p0_req_ready) got = 1'b1;
      else @(negedge clk);
    end
    chk("rstacc_granted", got, 1'b1);
    @(negedge clk);
    set_req(0, 1'b0, 4'b1111, 6'd0, 32'h00000055);
    #1;
    chk("rstacc_write_before", mem_write, 1'b1);
    rst = 1'b0;
    #1;
    chk("rstacc_write_gated", mem_write, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    do_req(0, 4'b1010, 6'd0, 32'h0, 32'h03020100, 1'b0, 1'b1, 1'b0);

    // Round-robin with both ports requesting continuously from reset.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b1, 4'b1010, 6'd0, 32'd0);
    set_req(1, 1'b1, 4'b1100, 6'd5, 32'd0);
    ng = 0;
    last_hs = 0;
    exp_g = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      r0 = p0_req_ready;
      r1 = p1_req_ready;
      chk("rr_ready_exclusive", {31'd0, r0 & r1}, 32'd0);
      if (r0 || r1) begin
        chk("rr_grant", r1, exp_g);
        if (ng > 0) chk("rr_spacing", cyc - last_hs, 32'd3);
        sbq.push_back('{r1 ? 1 : 0, r1 ? 32'h00000080 : 32'h03020100, 1'b0, cyc});
        exp_g = ~exp_g;
        last_hs = cyc;
        ng++;
      end
      @(negedge clk);
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    chk("rr_count", ng, 32'd4);

    // Fixed priority: port 1 starves while port 0 keeps requesting.
    repeat (3) @(negedge clk);
    fp_p0_valid = 1'b1;
    fp_p1_valid = 1'b1;
    fp_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("fp_p1_starved", fp_p1_ready, 1'b0);
      if (fp_p0_ready) fp_cnt++;
      @(negedge clk);
    end
    chk("fp_p0_grants", fp_cnt, 32'd4);
    fp_p0_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      #1;
      if (fp_p1_ready) got = 1'b1;
      else @(negedge clk);
    end
    chk("fp_p1_after_drop", got, 1'b1);
    @(negedge clk);
    fp_p1_valid = 1'b0;

    w = 0;
    while (sbq.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drained", sbq.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
